cic_interpolate: RTL

Variable-rate CIC interpolator, one real rail per instance; two instances form the I/Q transmit path mirroring the receive-side decimator. Accepts one input sample per strobe_in, emits `rate` output samples paced by a downstream tick (out_en), with end-of-burst propagation via last_in/last_out. Rate is programmed with the same rate/rate_stb pair as the decimator.

---
 rtl/cic_pkg.sv | 27 ++
 rtl/cic_comb_stage.sv | 30 +++
 rtl/cic_interpolate.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared CIC definitions used by the interpolator and the receive-side decimator:
// default rate width, internal width rule, run-time ceil(log2) helper and state type.
package cic_pkg;

    localparam int CIC_RATE_W = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cic_state_e;

    // Internal width that makes the modular comb/integrator arithmetic exact.
    function automatic int cic_iw(input int width, input int n, input int rate_w);
        return width + n * rate_w;
    endfunction

    // ceil(log2(v)); loop form so it also synthesises for a run-time operand.
    function automatic int cic_clog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One IW-bit first-difference stage; the delay register only advances on an
// accepted input sample and is cleared synchronously by clr.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int IW = 52
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [IW-1:0] din,
    output logic signed [IW-1:0] dout
);

    logic signed [IW-1:0] dly;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dly <= '0;
        end else if (clr) begin
            dly <= '0;
        end else if (en) begin
            dly <= din;
        end
    end

    assign dout = din - dly;

endmodule

// File: rtl/cic_interpolate.sv
// Variable-rate CIC interpolator for one real rail: comb at the input rate, zero-stuffing
// upsampler, integrators paced by out_en. Define CIC_INTERP_ROUND_EN for round-half-up scaling.
module cic_interpolate
    import cic_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int N      = 4,
    parameter int RATE_W = CIC_RATE_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    rate_stb,
    input  logic [RATE_W-1:0]       rate,
    input  logic                    strobe_in,
    input  logic signed [WIDTH-1:0] signal_in,
    input  logic                    last_in,
    output logic                    ready,
    input  logic                    out_en,
    output logic                    strobe_out,
    output logic signed [WIDTH-1:0] signal_out,
    output logic                    last_out
);

    localparam int IW   = cic_iw(WIDTH, N, RATE_W);
    localparam int SH_W = $clog2(IW + 1);

    // Gain rate^(N-1)/2^shift never exceeds 1, so taking the low bits cannot overflow.
    function automatic logic signed [WIDTH-1:0] scale_out(
        input logic signed [IW-1:0] v,
        input logic [SH_W-1:0]      sh
    );
        logic signed [IW-1:0] t;
        t = v;
`ifdef CIC_INTERP_ROUND_EN
        if (sh != '0) t = v + (IW'(1) << (sh - 1'b1));
`endif
        t = t >>> sh;
        return t[WIDTH-1:0];
    endfunction

    cic_state_e           st, st_nxt;
    logic [RATE_W-1:0]    ph, ph_nxt;
    logic [RATE_W-1:0]    rate_r, rate_eff;
    logic [SH_W-1:0]      shift_r, shift_nxt;
    logic                 last_r;
    logic                 accept, tick;

    logic signed [IW-1:0] sig_ext, comb_out, comb_q;
    logic signed [IW-1:0] up_in, acc;
    logic signed [IW-1:0] integ     [N];
    logic signed [IW-1:0] integ_nxt [N];

    // Control: phase counter / state and handshake
    always_comb begin
        rate_eff  = (rate == '0) ? RATE_W'(1) : rate;
        shift_nxt = SH_W'((N - 1) * cic_clog2(32'(rate_eff)));

        ready  = (st == ST_IDLE) || ((ph == RATE_W'(1)) && out_en);
        accept = strobe_in && ready && !rate_stb;
        tick   = out_en && (ph != '0) && !rate_stb;

        st_nxt = st;
        ph_nxt = ph;
        if (rate_stb) begin
            st_nxt = ST_IDLE;
            ph_nxt = '0;
        end else if (accept) begin
            st_nxt = ST_RUN;
            ph_nxt = rate_r;
        end else if (tick) begin
            ph_nxt = ph - 1'b1;
            if (ph == RATE_W'(1)) st_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st         <= ST_IDLE;
            ph         <= '0;
            rate_r     <= RATE_W'(1);
            shift_r    <= '0;
            last_r     <= 1'b0;
            strobe_out <= 1'b0;
            last_out   <= 1'b0;
        end else begin
            st         <= st_nxt;
            ph         <= ph_nxt;
            strobe_out <= tick;
            last_out   <= tick && (ph == RATE_W'(1)) && last_r;
            if (rate_stb) begin
                rate_r  <= rate_eff;
                shift_r <= shift_nxt;
                last_r  <= 1'b0;
            end else if (accept) begin
                last_r  <= last_in;
            end
        end
    end

    // Comb section at the input rate
    assign sig_ext = IW'(signal_in);

    for (genvar k = 0; k < N; k++) begin : g_comb
        logic signed [IW-1:0] d_in, d_out;
        if (k == 0) begin : g_head
            assign d_in = sig_ext;
        end else begin : g_link
            assign d_in = g_comb[k-1].d_out;
        end
        cic_comb_stage #(.IW(IW)) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (rate_stb),
            .en      (accept),
            .din     (d_in),
            .dout    (d_out)
        );
    end

    assign comb_out = g_comb[N-1].d_out;

    // Upsampler and integrator cascade at the output rate
    always_comb begin
        up_in = (ph == rate_r) ? comb_q : '0;
        acc   = up_in;
        for (int k = 0; k < N; k++) begin
            acc          = integ[k] + acc;
            integ_nxt[k] = acc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            comb_q     <= '0;
            signal_out <= '0;
            for (int k = 0; k < N; k++) integ[k] <= '0;
        end else if (rate_stb) begin
            comb_q <= '0;
            for (int k = 0; k < N; k++) integ[k] <= '0;
        end else begin
            if (accept) comb_q <= comb_out;
            if (tick) begin
                for (int k = 0; k < N; k++) integ[k] <= integ_nxt[k];
                signal_out <= scale_out(integ_nxt[N-1], shift_r);
            end
        end
    end

endmodule
